// File: rtl/ysyx_24080006_axi_pkg.sv
// Shared AXI4 encodings and responder state types for the SoC port bridge.
package ysyx_24080006_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_e;

endpackage

// File: rtl/ysyx_24080006_axi_skid.sv
// Generic valid/ready channel slice: two-entry skid buffer, or plain wires.
module ysyx_24080006_axi_skid #(
  parameter int WIDTH  = 8,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (ENABLE) begin : g_slice
      logic             out_valid_p0;
      logic [WIDTH-1:0] out_data_p0;
      logic             skid_valid_p0;
      logic [WIDTH-1:0] skid_data_p0;
      logic             in_ready_p0;
      logic             push;
      logic             load;

      assign push = in_valid && in_ready_p0;
      assign load = !out_valid_p0 || out_ready;

      // Output register refills from the skid entry first, so order is kept;
      // in_ready is a flop that is low only while the skid entry is occupied.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          out_valid_p0  <= 1'b0;
          out_data_p0   <= '0;
          skid_valid_p0 <= 1'b0;
          skid_data_p0  <= '0;
          in_ready_p0   <= 1'b0;
        end else if (load) begin
          in_ready_p0 <= 1'b1;
          if (skid_valid_p0) begin
            out_valid_p0  <= 1'b1;
            out_data_p0   <= skid_data_p0;
            skid_valid_p0 <= 1'b0;
          end else if (push) begin
            out_valid_p0 <= 1'b1;
            out_data_p0  <= in_data;
          end else begin
            out_valid_p0 <= 1'b0;
          end
        end else if (push) begin
          skid_valid_p0 <= 1'b1;
          skid_data_p0  <= in_data;
          in_ready_p0   <= 1'b0;
        end else begin
          in_ready_p0 <= !skid_valid_p0;
        end
      end

      assign in_ready  = in_ready_p0;
      assign out_valid = out_valid_p0;
      assign out_data  = out_data_p0;
    end else begin : g_wire
      logic unused_clock;
      assign unused_clock = clock;
      // Handshakes are held off while reset is asserted.
      assign out_valid = in_valid && reset;
      assign in_ready  = out_ready && reset;
      assign out_data  = reset ? in_data : '0;
    end
  endgenerate

endmodule

// File: rtl/ysyx_24080006_axi_port_bridge.sv
// SoC AXI4 port bridge: sliced core-to-io master path plus a DECERR slave responder.
module ysyx_24080006_axi_port_bridge
  import ysyx_24080006_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter bit REG_AW = 1'b1,
  parameter bit REG_W  = 1'b1,
  parameter bit REG_B  = 1'b0,
  parameter bit REG_AR = 1'b1,
  parameter bit REG_R  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  // core master interface
  input  logic                core_awvalid,
  output logic                core_awready,
  input  logic [ADDR_W-1:0]   core_awaddr,
  input  logic [ID_W-1:0]     core_awid,
  input  logic [7:0]          core_awlen,
  input  logic [2:0]          core_awsize,
  input  logic [1:0]          core_awburst,
  input  logic                core_wvalid,
  output logic                core_wready,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wstrb,
  input  logic                core_wlast,
  output logic                core_bvalid,
  input  logic                core_bready,
  output logic [1:0]          core_bresp,
  output logic [ID_W-1:0]     core_bid,
  input  logic                core_arvalid,
  output logic                core_arready,
  input  logic [ADDR_W-1:0]   core_araddr,
  input  logic [ID_W-1:0]     core_arid,
  input  logic [7:0]          core_arlen,
  input  logic [2:0]          core_arsize,
  input  logic [1:0]          core_arburst,
  output logic                core_rvalid,
  input  logic                core_rready,
  output logic [1:0]          core_rresp,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rlast,
  output logic [ID_W-1:0]     core_rid,
  // io master pins
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid,
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [1:0]          io_master_rresp,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,
  // io slave pins
  input  logic                io_slave_awvalid,
  output logic                io_slave_awready,
  input  logic [ADDR_W-1:0]   io_slave_awaddr,
  input  logic [ID_W-1:0]     io_slave_awid,
  input  logic [7:0]          io_slave_awlen,
  input  logic [2:0]          io_slave_awsize,
  input  logic [1:0]          io_slave_awburst,
  input  logic                io_slave_wvalid,
  output logic                io_slave_wready,
  input  logic [DATA_W-1:0]   io_slave_wdata,
  input  logic [DATA_W/8-1:0] io_slave_wstrb,
  input  logic                io_slave_wlast,
  output logic                io_slave_bvalid,
  input  logic                io_slave_bready,
  output logic [1:0]          io_slave_bresp,
  output logic [ID_W-1:0]     io_slave_bid,
  input  logic                io_slave_arvalid,
  output logic                io_slave_arready,
  input  logic [ADDR_W-1:0]   io_slave_araddr,
  input  logic [ID_W-1:0]     io_slave_arid,
  input  logic [7:0]          io_slave_arlen,
  input  logic [2:0]          io_slave_arsize,
  input  logic [1:0]          io_slave_arburst,
  output logic                io_slave_rvalid,
  input  logic                io_slave_rready,
  output logic [1:0]          io_slave_rresp,
  output logic [DATA_W-1:0]   io_slave_rdata,
  output logic                io_slave_rlast,
  output logic [ID_W-1:0]     io_slave_rid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AX_PW  = ADDR_W + ID_W + 13;
  localparam int W_PW   = DATA_W + STRB_W + 1;
  localparam int B_PW   = 2 + ID_W;
  localparam int R_PW   = 2 + DATA_W + 1 + ID_W;

  // ---- master side: one slice per channel, payloads packed ----
  logic [AX_PW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_PW-1:0]  w_in, w_out;
  logic [B_PW-1:0]  b_in, b_out;
  logic [R_PW-1:0]  r_in, r_out;

  assign aw_in = {core_awaddr, core_awid, core_awlen, core_awsize, core_awburst};
  assign {io_master_awaddr, io_master_awid, io_master_awlen, io_master_awsize,
          io_master_awburst} = aw_out;
  assign w_in  = {core_wdata, core_wstrb, core_wlast};
  assign {io_master_wdata, io_master_wstrb, io_master_wlast} = w_out;
  assign b_in  = {io_master_bresp, io_master_bid};
  assign {core_bresp, core_bid} = b_out;
  assign ar_in = {core_araddr, core_arid, core_arlen, core_arsize, core_arburst};
  assign {io_master_araddr, io_master_arid, io_master_arlen, io_master_arsize,
          io_master_arburst} = ar_out;
  assign r_in  = {io_master_rresp, io_master_rdata, io_master_rlast, io_master_rid};
  assign {core_rresp, core_rdata, core_rlast, core_rid} = r_out;

  ysyx_24080006_axi_skid #(.WIDTH(AX_PW), .ENABLE(REG_AW)) u_aw (
    .clock(clock), .reset(reset),
    .in_valid(core_awvalid), .in_ready(core_awready), .in_data(aw_in),
    .out_valid(io_master_awvalid), .out_ready(io_master_awready), .out_data(aw_out));

  ysyx_24080006_axi_skid #(.WIDTH(W_PW), .ENABLE(REG_W)) u_w (
    .clock(clock), .reset(reset),
    .in_valid(core_wvalid), .in_ready(core_wready), .in_data(w_in),
    .out_valid(io_master_wvalid), .out_ready(io_master_wready), .out_data(w_out));

  ysyx_24080006_axi_skid #(.WIDTH(B_PW), .ENABLE(REG_B)) u_b (
    .clock(clock), .reset(reset),
    .in_valid(io_master_bvalid), .in_ready(io_master_bready), .in_data(b_in),
    .out_valid(core_bvalid), .out_ready(core_bready), .out_data(b_out));

  ysyx_24080006_axi_skid #(.WIDTH(AX_PW), .ENABLE(REG_AR)) u_ar (
    .clock(clock), .reset(reset),
    .in_valid(core_arvalid), .in_ready(core_arready), .in_data(ar_in),
    .out_valid(io_master_arvalid), .out_ready(io_master_arready), .out_data(ar_out));

  ysyx_24080006_axi_skid #(.WIDTH(R_PW), .ENABLE(REG_R)) u_r (
    .clock(clock), .reset(reset),
    .in_valid(io_master_rvalid), .in_ready(io_master_rready), .in_data(r_in),
    .out_valid(core_rvalid), .out_ready(core_rready), .out_data(r_out));

  // ---- slave side: DECERR responder ----
  wr_state_e       wr_state;
  rd_state_e       rd_state;
  logic [7:0]      rd_cnt;

  // Write responder: accept one AW, sink its beats up to wlast, answer DECERR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state         <= WR_IDLE;
      io_slave_awready <= 1'b0;
      io_slave_wready  <= 1'b0;
      io_slave_bvalid  <= 1'b0;
      io_slave_bresp   <= RESP_OKAY;
      io_slave_bid     <= '0;
    end else begin
      case (wr_state)
        WR_IDLE:
          if (io_slave_awready && io_slave_awvalid) begin
            io_slave_bid     <= io_slave_awid;
            io_slave_awready <= 1'b0;
            io_slave_wready  <= 1'b1;
            wr_state         <= WR_DATA;
          end else begin
            io_slave_awready <= 1'b1;
          end
        WR_DATA:
          if (io_slave_wvalid && io_slave_wlast) begin
            io_slave_wready <= 1'b0;
            io_slave_bvalid <= 1'b1;
            io_slave_bresp  <= RESP_DECERR;
            wr_state        <= WR_RESP;
          end
        WR_RESP:
          if (io_slave_bready) begin
            io_slave_bvalid  <= 1'b0;
            io_slave_bresp   <= RESP_OKAY;
            io_slave_awready <= 1'b1;
            wr_state         <= WR_IDLE;
          end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read responder: accept one AR, return arlen+1 zero beats with DECERR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state         <= RD_IDLE;
      rd_cnt           <= 8'd0;
      io_slave_arready <= 1'b0;
      io_slave_rvalid  <= 1'b0;
      io_slave_rresp   <= RESP_OKAY;
      io_slave_rlast   <= 1'b0;
      io_slave_rid     <= '0;
    end else begin
      case (rd_state)
        RD_IDLE:
          if (io_slave_arready && io_slave_arvalid) begin
            io_slave_rid     <= io_slave_arid;
            rd_cnt           <= io_slave_arlen;
            io_slave_arready <= 1'b0;
            io_slave_rvalid  <= 1'b1;
            io_slave_rresp   <= RESP_DECERR;
            io_slave_rlast   <= (io_slave_arlen == 8'd0);
            rd_state         <= RD_DATA;
          end else begin
            io_slave_arready <= 1'b1;
          end
        RD_DATA:
          if (io_slave_rready) begin
            if (io_slave_rlast) begin
              io_slave_rvalid  <= 1'b0;
              io_slave_rresp   <= RESP_OKAY;
              io_slave_rlast   <= 1'b0;
              io_slave_arready <= 1'b1;
              rd_state         <= RD_IDLE;
            end else begin
              rd_cnt         <= rd_cnt - 8'd1;
              io_slave_rlast <= (rd_cnt == 8'd1);
            end
          end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign io_slave_rdata = '0;

  logic unused_slave;
  assign unused_slave = ^{io_slave_awaddr, io_slave_awlen, io_slave_awsize, io_slave_awburst,
                          io_slave_wdata, io_slave_wstrb, io_slave_araddr, io_slave_arsize,
                          io_slave_arburst};

endmodule

// File: tb/tb_ysyx_24080006_axi_port_bridge.sv
// Directed/randomized bench for the AXI port bridge with a queue-based scoreboard.
module tb_ysyx_24080006_axi_port_bridge;
  import ysyx_24080006_axi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        core_awvalid = 0, core_awready;
  logic [31:0] core_awaddr = 0;
  logic [3:0]  core_awid = 0;
  logic [7:0]  core_awlen = 0;
  logic [2:0]  core_awsize = 0;
  logic [1:0]  core_awburst = 0;
  logic        core_wvalid = 0, core_wready;
  logic [31:0] core_wdata = 0;
  logic [3:0]  core_wstrb = 0;
  logic        core_wlast = 0;
  logic        core_bvalid, core_bready = 0;
  logic [1:0]  core_bresp;
  logic [3:0]  core_bid;
  logic        core_arvalid = 0, core_arready;
  logic [31:0] core_araddr = 0;
  logic [3:0]  core_arid = 0;
  logic [7:0]  core_arlen = 0;
  logic [2:0]  core_arsize = 0;
  logic [1:0]  core_arburst = 0;
  logic        core_rvalid, core_rready = 0;
  logic [1:0]  core_rresp;
  logic [31:0] core_rdata;
  logic        core_rlast;
  logic [3:0]  core_rid;

  logic        io_master_awvalid, io_master_awready = 0;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_wvalid, io_master_wready = 0;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_wlast;
  logic        io_master_bvalid = 0, io_master_bready;
  logic [1:0]  io_master_bresp = 0;
  logic [3:0]  io_master_bid = 0;
  logic        io_master_arvalid, io_master_arready = 0;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid = 0, io_master_rready;
  logic [1:0]  io_master_rresp = 0;
  logic [31:0] io_master_rdata = 0;
  logic        io_master_rlast = 0;
  logic [3:0]  io_master_rid = 0;

  logic        io_slave_awvalid = 0, io_slave_awready;
  logic [31:0] io_slave_awaddr = 0;
  logic [3:0]  io_slave_awid = 0;
  logic [7:0]  io_slave_awlen = 0;
  logic [2:0]  io_slave_awsize = 0;
  logic [1:0]  io_slave_awburst = 0;
  logic        io_slave_wvalid = 0, io_slave_wready;
  logic [31:0] io_slave_wdata = 0;
  logic [3:0]  io_slave_wstrb = 0;
  logic        io_slave_wlast = 0;
  logic        io_slave_bvalid, io_slave_bready = 0;
  logic [1:0]  io_slave_bresp;
  logic [3:0]  io_slave_bid;
  logic        io_slave_arvalid = 0, io_slave_arready;
  logic [31:0] io_slave_araddr = 0;
  logic [3:0]  io_slave_arid = 0;
  logic [7:0]  io_slave_arlen = 0;
  logic [2:0]  io_slave_arsize = 0;
  logic [1:0]  io_slave_arburst = 0;
  logic        io_slave_rvalid, io_slave_rready = 0;
  logic [1:0]  io_slave_rresp;
  logic [31:0] io_slave_rdata;
  logic        io_slave_rlast;
  logic [3:0]  io_slave_rid;

  ysyx_24080006_axi_port_bridge dut (
    .clock(clock), .reset(reset),
    .core_awvalid(core_awvalid), .core_awready(core_awready), .core_awaddr(core_awaddr),
    .core_awid(core_awid), .core_awlen(core_awlen), .core_awsize(core_awsize),
    .core_awburst(core_awburst),
    .core_wvalid(core_wvalid), .core_wready(core_wready), .core_wdata(core_wdata),
    .core_wstrb(core_wstrb), .core_wlast(core_wlast),
    .core_bvalid(core_bvalid), .core_bready(core_bready), .core_bresp(core_bresp),
    .core_bid(core_bid),
    .core_arvalid(core_arvalid), .core_arready(core_arready), .core_araddr(core_araddr),
    .core_arid(core_arid), .core_arlen(core_arlen), .core_arsize(core_arsize),
    .core_arburst(core_arburst),
    .core_rvalid(core_rvalid), .core_rready(core_rready), .core_rresp(core_rresp),
    .core_rdata(core_rdata), .core_rlast(core_rlast), .core_rid(core_rid),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_slave_awvalid(io_slave_awvalid), .io_slave_awready(io_slave_awready),
    .io_slave_awaddr(io_slave_awaddr), .io_slave_awid(io_slave_awid),
    .io_slave_awlen(io_slave_awlen), .io_slave_awsize(io_slave_awsize),
    .io_slave_awburst(io_slave_awburst),
    .io_slave_wvalid(io_slave_wvalid), .io_slave_wready(io_slave_wready),
    .io_slave_wdata(io_slave_wdata), .io_slave_wstrb(io_slave_wstrb),
    .io_slave_wlast(io_slave_wlast),
    .io_slave_bvalid(io_slave_bvalid), .io_slave_bready(io_slave_bready),
    .io_slave_bresp(io_slave_bresp), .io_slave_bid(io_slave_bid),
    .io_slave_arvalid(io_slave_arvalid), .io_slave_arready(io_slave_arready),
    .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid),
    .io_slave_arlen(io_slave_arlen), .io_slave_arsize(io_slave_arsize),
    .io_slave_arburst(io_slave_arburst),
    .io_slave_rvalid(io_slave_rvalid), .io_slave_rready(io_slave_rready),
    .io_slave_rresp(io_slave_rresp), .io_slave_rdata(io_slave_rdata),
    .io_slave_rlast(io_slave_rlast), .io_slave_rid(io_slave_rid));

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output-side handshake monitors: what actually left the bridge, in order.
  logic [63:0] mon_aw[$], mon_w[$], mon_ar[$], mon_r[$];
  int unsigned mon_w_cyc[$];
  always @(posedge clock) begin
    if (io_master_awvalid && io_master_awready)
      mon_aw.push_back(64'({io_master_awaddr, io_master_awid, io_master_awlen,
                            io_master_awsize, io_master_awburst}));
    if (io_master_wvalid && io_master_wready) begin
      mon_w.push_back(64'({io_master_wdata, io_master_wstrb, io_master_wlast}));
      mon_w_cyc.push_back(cyc);
    end
    if (io_master_arvalid && io_master_arready)
      mon_ar.push_back(64'({io_master_araddr, io_master_arid, io_master_arlen,
                            io_master_arsize, io_master_arburst}));
    if (core_rvalid && core_rready)
      mon_r.push_back(64'({core_rresp, core_rdata, core_rlast, core_rid}));
  end

  // Reference model: every accepted input beat must come out once, in order.
  logic [63:0] exp_aw[$], exp_w[$], exp_ar[$], exp_r[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit toggle_aw = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic old;
    @(posedge clock);
    #1;
    if (toggle_aw) begin
      old = core_awready;
      io_master_awready = ~io_master_awready;
      #1;
      chk("aw_ready_no_comb_path", 64'(core_awready), 64'(old));
    end
  endtask

  task automatic cmp_q(input string tag, input logic [63:0] m[$], input logic [63:0] e[$]);
    chk({tag, "_count"}, 64'(m.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < m.size(); i++) chk(tag, m[i], e[i]);
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    bit done = 0;
    core_awvalid = 1; core_awaddr = a; core_awid = id; core_awlen = len;
    core_awsize = sz; core_awburst = bu;
    for (int k = 0; k < 200 && !done; k++) begin
      if (core_awready) begin
        exp_aw.push_back(64'({a, id, len, sz, bu}));
        done = 1;
      end
      step();
    end
    if (!done) chk("aw_accept_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l,
                        output int steps);
    bit done = 0;
    steps = 0;
    core_wvalid = 1; core_wdata = d; core_wstrb = s; core_wlast = l;
    for (int k = 0; k < 200 && !done; k++) begin
      if (core_wready) begin
        exp_w.push_back(64'({d, s, l}));
        done = 1;
      end
      step();
      steps++;
    end
    if (!done) chk("w_accept_timeout", 0, 1);
  endtask

  task automatic send_r(input logic [31:0] d, input logic [3:0] id, input logic l);
    bit done = 0;
    io_master_rvalid = 1; io_master_rdata = d; io_master_rid = id;
    io_master_rresp = RESP_OKAY; io_master_rlast = l;
    for (int k = 0; k < 200 && !done; k++) begin
      if (io_master_rready) begin
        exp_r.push_back(64'({RESP_OKAY, d, l, id}));
        done = 1;
      end
      step();
    end
    if (!done) chk("r_accept_timeout", 0, 1);
  endtask

  // Issue one AR to the slave responder and collect the whole DECERR burst.
  task automatic rd_burst(input logic [3:0] id, input logic [7:0] len, input bit stall);
    bit done = 0;
    int beats = 0;
    io_slave_arvalid = 1; io_slave_arid = id; io_slave_arlen = len;
    io_slave_araddr = $urandom;
    for (int k = 0; k < 50 && !done; k++) begin
      if (io_slave_arready) done = 1;
      step();
    end
    io_slave_arvalid = 0;
    if (!done) chk("rd_ar_timeout", 0, 1);
    for (int k = 0; k < 3000 && beats <= int'(len); k++) begin
      io_slave_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (io_slave_rvalid && io_slave_rready) begin
        chk("rd_beat", 64'({io_slave_rlast, io_slave_rid, io_slave_rresp, io_slave_rdata}),
            64'({(beats == int'(len)), id, RESP_DECERR, 32'h0}));
        beats++;
      end
      step();
    end
    io_slave_rready = 0;
    chk("rd_beat_count", 64'(beats), 64'(int'(len) + 1));
    chk("rd_idle_after", 64'(io_slave_rvalid), 0);
  endtask

  // Write to the slave responder: AW then nbeats W beats, then check the DECERR B.
  task automatic sl_write(input logic [3:0] id, input int nbeats);
    bit done = 0;
    io_slave_awvalid = 1; io_slave_awid = id; io_slave_awlen = 8'(nbeats - 1);
    for (int k = 0; k < 50 && !done; k++) begin
      if (io_slave_awready) done = 1;
      step();
    end
    io_slave_awvalid = 0;
    if (!done) chk("sl_aw_timeout", 0, 1);
    chk("sl_awready_busy", 64'(io_slave_awready), 0);
    for (int b = 0; b < nbeats; b++) begin
      done = 0;
      io_slave_wvalid = 1; io_slave_wdata = $urandom; io_slave_wlast = (b == nbeats - 1);
      for (int k = 0; k < 50 && !done; k++) begin
        if (io_slave_wready) done = 1;
        step();
      end
      if (!done) chk("sl_w_timeout", 0, 1);
    end
    io_slave_wvalid = 0; io_slave_wlast = 0;
    repeat (2) begin
      chk("sl_b_pending", 64'({io_slave_bvalid, io_slave_bid, io_slave_bresp, io_slave_awready,
                               io_slave_wready}),
          64'({1'b1, id, RESP_DECERR, 1'b0, 1'b0}));
      step();
    end
    io_slave_bready = 1;
    step();
    io_slave_bready = 0;
    chk("sl_b_done", 64'({io_slave_bvalid, io_slave_awready}), 64'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  id;
    int          steps, total;
    logic [63:0] tail[$];

    // Reset: all valids, readies and payload outputs low, even with pass-through inputs up.
    core_bready = 1; io_master_bvalid = 1; io_master_bid = 4'hA; io_master_bresp = RESP_SLVERR;
    repeat (3) step();
    chk("reset_handshakes", 64'({core_awready, core_wready, core_arready, core_bvalid,
                                 core_rvalid, io_master_awvalid, io_master_wvalid,
                                 io_master_arvalid, io_master_bready, io_master_rready,
                                 io_slave_awready, io_slave_wready, io_slave_bvalid,
                                 io_slave_arready, io_slave_rvalid}), 0);
    chk("reset_payloads", 64'({core_bid, core_bresp, core_rid, io_master_awid, io_slave_bresp,
                               io_slave_rresp, io_slave_bid, io_slave_rid}), 0);
    core_bready = 0; io_master_bvalid = 0;
    reset = 1;
    step();
    chk("post_reset_ready", 64'({core_awready, core_wready, core_arready, io_master_rready,
                                 io_slave_awready, io_slave_arready, io_slave_wready}),
        64'(7'b1111110));

    // AR through the slice with one cycle latency, then a 4-beat R burst back.
    io_master_arready = 1;
    id = 4'($urandom);
    core_arvalid = 1; core_araddr = 32'h8000_0000; core_arid = id; core_arlen = 8'd3;
    core_arsize = 3'd2; core_arburst = BURST_INCR;
    exp_ar.push_back(64'({32'h8000_0000, id, 8'd3, 3'd2, BURST_INCR}));
    chk("ar_not_yet", 64'(io_master_arvalid), 0);
    step();
    core_arvalid = 0;
    chk("ar_latency", 64'(io_master_arvalid), 1);
    step();
    chk("ar_drained", 64'(io_master_arvalid), 0);
    cmp_q("ar_payload", mon_ar, exp_ar);
    core_rready = 1;
    for (int b = 0; b < 4; b++) begin
      send_r($urandom, id, b == 3);
      if (b == 0) chk("r_latency", 64'(core_rvalid), 1);
    end
    io_master_rvalid = 0;
    repeat (3) step();
    cmp_q("r_order", mon_r, exp_r);

    // AW backpressure: io_master_awready flips every cycle, core keeps pushing.
    io_master_awready = 0;
    toggle_aw = 1;
    for (int i = 0; i < 8; i++)
      send_aw($urandom, 4'($urandom), 8'($urandom), 3'($urandom_range(0, 2)),
              2'($urandom_range(0, 2)));
    core_awvalid = 0;
    repeat (6) step();
    toggle_aw = 0;
    io_master_awready = 1;
    repeat (2) step();
    cmp_q("aw_backpressure", mon_aw, exp_aw);

    // Stream 16 W beats with the sink always ready: one beat per cycle.
    io_master_wready = 1;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send_w($urandom, 4'($urandom), i == 15, steps);
      total += steps;
    end
    core_wvalid = 0;
    repeat (2) step();
    chk("w_stream_cycles", 64'(total), 16);
    cmp_q("w_stream", mon_w, exp_w);
    if (mon_w_cyc.size() >= 16)
      chk("w_stream_span", 64'(mon_w_cyc[mon_w_cyc.size() - 1] - mon_w_cyc[mon_w_cyc.size() - 16]),
          15);
    else
      chk("w_stream_span_count", 64'(mon_w_cyc.size()), 16);

    // B channel is a zero-latency wire path.
    io_master_bvalid = 1; io_master_bid = 4'($urandom); io_master_bresp = RESP_SLVERR;
    core_bready = 1;
    #1;
    chk("b_wire", 64'({core_bvalid, core_bid, core_bresp, io_master_bready}),
        64'({1'b1, io_master_bid, RESP_SLVERR, 1'b1}));
    io_master_bvalid = 0; core_bready = 0;
    step();

    // Slave write: W arriving before AW stalls, then id=5 three-beat write, then a random one.
    io_slave_wvalid = 1; io_slave_wlast = 0;
    repeat (2) begin
      chk("sl_w_before_aw", 64'(io_slave_wready), 0);
      step();
    end
    sl_write(4'd5, 3);
    sl_write(4'($urandom), 1);

    // Slave read: single beat, then 256 beats under random rready stalls.
    rd_burst(4'd9, 8'd0, 1'b0);
    rd_burst(4'd9, 8'd255, 1'b1);

    // Reset in the middle of a 16-beat read after 7 beats.
    io_slave_arvalid = 1; io_slave_arid = 4'($urandom); io_slave_arlen = 8'd15;
    step();
    io_slave_arvalid = 0;
    io_slave_rready = 1;
    begin
      int got = 0;
      for (int k = 0; k < 50 && got < 7; k++) begin
        if (io_slave_rvalid) got++;
        step();
      end
      chk("mid_read_beats", 64'(got), 7);
    end
    chk("mid_read_active", 64'(io_slave_rvalid), 1);
    reset = 0;
    #1;
    chk("mid_reset_valids", 64'({io_slave_rvalid, io_slave_bvalid, io_slave_arready,
                                 io_slave_awready, core_rvalid, core_bvalid,
                                 io_master_awvalid, io_master_wvalid, io_master_arvalid}), 0);
    repeat (2) step();
    chk("mid_reset_hold", 64'(io_slave_rvalid), 0);
    reset = 1;
    step();
    chk("post_mid_reset", 64'({io_slave_rvalid, io_slave_arready}), 64'(2'b01));
    io_slave_rready = 0;
    rd_burst(4'($urandom), 8'($urandom_range(1, 6)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
